// File: rtl/shift_lhs_seq_if.sv
// Request/result bundle of the sequential LHS shifter.
// master drives start/op/amount/carryIn/LhsIn; slave returns busy/done/carryOut/LhsOut.
interface shift_lhs_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 5
);
    logic                  start;
    logic [2:0]            op;
    logic [AMT_WIDTH-1:0]  amount;
    logic                  carryIn;
    logic [DATA_WIDTH-1:0] LhsIn;
    logic                  busy;
    logic                  done;
    logic                  carryOut;
    logic [DATA_WIDTH-1:0] LhsOut;

    modport master (
        output start, op, amount, carryIn, LhsIn,
        input  busy, done, carryOut, LhsOut
    );

    modport slave (
        input  start, op, amount, carryIn, LhsIn,
        output busy, done, carryOut, LhsOut
    );
endinterface

// File: rtl/shift_lhs_seq.sv
// Sequential shifter/rotator for the ALU LHS operand, one bit per clock.
// Ports: clk, reset (sync, active-high), bus (slave side of shift_lhs_seq_if).
module shift_lhs_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 5
) (
    input logic             clk,
    input logic             reset,
    shift_lhs_seq_if.slave  bus
);
    localparam logic [2:0] OP_PASS  = 3'd0;
    localparam logic [2:0] OP_RCL   = 3'd1;
    localparam logic [2:0] OP_RCR   = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd3;
    localparam logic [2:0] OP_SHL   = 3'd4;
    localparam logic [2:0] OP_SHR   = 3'd5;
    localparam logic [2:0] OP_ASR   = 3'd6;
    localparam logic [2:0] OP_ROL   = 3'd7;

    localparam int W = DATA_WIDTH;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state;
    logic [AMT_WIDTH-1:0] cnt;
    logic [2:0]           op_q;
    logic [W-1:0]         data;
    logic                 carry;
    logic                 busy;
    logic                 done;

    logic [W-1:0]         step_data;
    logic                 step_carry;

    // One bit position of the latched mode applied to the current state.
    always_comb begin
        step_data  = data;
        step_carry = carry;
        unique case (op_q)
            OP_RCL: begin
                step_data  = {data[W-2:0], carry};
                step_carry = data[W-1];
            end
            OP_RCR: begin
                step_data  = {carry, data[W-1:1]};
                step_carry = data[0];
            end
            OP_SHL: begin
                step_data  = {data[W-2:0], 1'b0};
                step_carry = data[W-1];
            end
            OP_SHR: begin
                step_data  = {1'b0, data[W-1:1]};
                step_carry = data[0];
            end
            OP_ASR: begin
                step_data  = {data[W-1], data[W-1:1]};
                step_carry = data[0];
            end
            OP_ROL: begin
                step_data  = {data[W-2:0], data[W-1]};
                step_carry = data[W-1];
            end
            default: begin
                step_data  = data;
                step_carry = carry;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_PASS;
            data  <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        if (bus.op == OP_PASS) begin
                            data  <= bus.LhsIn;
                            carry <= 1'b0;
                            done  <= 1'b1;
                        end else if (bus.op == OP_CLEAR) begin
                            data  <= '0;
                            carry <= 1'b0;
                            done  <= 1'b1;
                        end else if (bus.amount == '0) begin
                            data  <= bus.LhsIn;
                            carry <= bus.carryIn;
                            done  <= 1'b1;
                        end else begin
                            data  <= bus.LhsIn;
                            carry <= bus.carryIn;
                            cnt   <= bus.amount;
                            op_q  <= bus.op;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data  <= step_data;
                    carry <= step_carry;
                    cnt   <= cnt - 1'b1;
                    // Last step: hand the result over in the same edge.
                    if (cnt == AMT_WIDTH'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.LhsOut   = data;
    assign bus.carryOut = carry;
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule
